// File: rtl/uart_pkg.sv
// Shared UART definitions: baud constant, shifter state encoding and
// status-word bit positions used by both the receiver and the transmitter.
package uart_pkg;

    // 25 MHz / 115200 baud, rounded down
    localparam int CLKS_PER_BIT_DEFAULT = 217;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Status word layout
    localparam int BUSY_BIT   = 15;
    localparam int ACTIVE_BIT = 0;

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side bus of the UART transmitter: write strobe, write data, status word.
//
// Handshake: a write is taken on any rising clock edge where load=1 and the
// status word's busy bit (out[15]) is 0 in that same cycle. A load seen while
// busy is 1 is discarded with no side effect; the CPU must poll busy first.
interface uart_tx_if;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;

    modport master (output load, output in, input out);
    modport slave  (input load, input in, output out);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while the shifter is running and
// pulses bit_done on the last cycle of every serial bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic clear,
    input  logic run,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] bit_cnt;

    // Counter is held at zero while idle and re-armed when a new frame starts.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            bit_cnt <= '0;
        end else if (restart || !run) begin
            bit_cnt <= '0;
        end else if (bit_cnt == LAST) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign bit_done = run && (bit_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register in
// front of the shift register, so a queued byte follows the current frame's
// stop bit with no idle gap. TX is registered and idles high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       clear,
    uart_tx_if.slave   bus,
    output logic       TX,
    output tx_state_t  dbg_state
);

    tx_state_t   state, state_next;
    logic [7:0]  hold_data, hold_data_next;
    logic        hold_full, hold_full_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic        tx_reg, tx_next;
    logic        accept;
    logic        transfer;
    logic        bit_done;
    logic [15:0] status;
    logic        unused_upper;

    // Only the low byte of the write data is meaningful.
    assign unused_upper = ^bus.in[15:8];

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .clear    (clear),
        .run      (state != IDLE),
        .restart  (transfer),
        .bit_done (bit_done)
    );

    // State, holding register, shifter and line registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= state_next;
            hold_data <= hold_data_next;
            hold_full <= hold_full_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            tx_reg    <= tx_next;
        end
    end

    // Next-state, holding-register handoff and next line level.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        transfer     = 1'b0;
        tx_next      = 1'b1;

        // Accept and transfer are mutually exclusive: one needs the holding
        // register empty, the other needs it full. A load coinciding with a
        // transfer is therefore dropped.
        accept = bus.load && !hold_full;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    transfer   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (hold_full) begin
                        transfer   = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (transfer) begin
            shift_next = hold_data;
        end

        hold_full_next = accept ? 1'b1 : (transfer ? 1'b0 : hold_full);
        hold_data_next = accept ? bus.in[7:0] : hold_data;

        // Line level is registered, so derive it from where the FSM is going.
        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[bit_idx_next];
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    // Status word: busy while a byte waits, active while a frame is on the wire.
    always_comb begin
        status             = '0;
        status[BUSY_BIT]   = hold_full;
        status[ACTIVE_BIT] = (state != IDLE);
    end

    assign bus.out   = status;
    assign TX        = tx_reg;
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset/idle, single frames, back-to-back frames
// with a dropped write, and an asynchronous clear in the middle of a frame.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB   = 217;
    localparam int FRAME = 10 * CPB;

    logic      clk;
    logic      clear;
    logic      TX;
    tx_state_t dbg_state;
    int        checks;
    int        errors;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .bus       (bus),
        .TX        (TX),
        .dbg_state (dbg_state)
    );

    // Clock: 10 ns period, inputs driven and outputs sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse load for one rising edge; returns at the negedge after that edge.
    task automatic do_write(input logic [15:0] data);
        bus.load = 1'b1;
        bus.in   = data;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            check({tag, " tx"}, {15'b0, TX}, 16'h0001);
            check({tag, " status"}, bus.out, 16'h0000);
            @(negedge clk);
        end
    endtask

    // Called at the first negedge of a start bit. f is the hand-built 10-bit
    // frame, f[0] = start bit. Optional writes at frame cycles wr1_at/wr2_at.
    task automatic frame(input string tag, input logic [9:0] f,
                         input int wr1_at, input logic [15:0] wr1_data,
                         input int wr2_at, input logic [15:0] wr2_data);
        for (int c = 0; c < FRAME; c++) begin
            int   j;
            int   off;
            logic busy;
            j    = c / CPB;
            off  = c % CPB;
            busy = (wr1_at >= 0) && (c > wr1_at);
            if (off == 0 || off == CPB - 1) begin
                check({tag, " tx"}, {15'b0, TX}, {15'b0, f[j]});
                check({tag, " status"}, bus.out, {busy, 14'b0, 1'b1});
            end
            if (c == wr1_at) begin
                bus.load = 1'b1;
                bus.in   = wr1_data;
            end else if (c == wr2_at) begin
                bus.load = 1'b1;
                bus.in   = wr2_data;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clear    = 1'b1;
        bus.load = 1'b0;
        bus.in   = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx", {15'b0, TX}, 16'h0001);
        check("reset status", bus.out, 16'h0000);
        check("reset state", {14'b0, dbg_state}, 16'h0000);
        clear = 1'b0;
        @(negedge clk);
        idle_check("idle", 1000);

        // Single write 0x55: hold_full visible, then transfer next edge
        do_write(16'h0055);
        check("w55 queued status", bus.out, 16'h8000);
        check("w55 queued tx", {15'b0, TX}, 16'h0001);
        @(negedge clk);
        frame("f55", 10'b1010101010, -1, 16'h0, -1, 16'h0);
        check("f55 end status", bus.out, 16'h0000);
        check("f55 end tx", {15'b0, TX}, 16'h0001);
        idle_check("post55", 20);

        // Upper byte ignored: 0x41
        do_write(16'hFF41);
        check("w41 queued status", bus.out, 16'h8000);
        @(negedge clk);
        frame("f41", 10'b1010000010, -1, 16'h0, -1, 16'h0);
        idle_check("post41", 20);

        // Back-to-back: 0x12 then 0x34 queued mid-frame, third write dropped
        do_write(16'h0012);
        @(negedge clk);
        frame("f12", 10'b1000100100, 500, 16'h0034, 1000, 16'h0056);
        frame("f34", 10'b1001101000, -1, 16'h0, -1, 16'h0);
        idle_check("post34", 300);

        // Clear during data bit 3 of 0x00 with 0x77 queued
        do_write(16'h0000);
        @(negedge clk);
        for (int c = 0; c < 4 * CPB + 100; c++) begin
            bus.load = (c == 500);
            bus.in   = 16'h0077;
            @(negedge clk);
        end
        bus.load = 1'b0;
        check("pre-clear tx", {15'b0, TX}, 16'h0000);
        check("pre-clear status", bus.out, 16'h8001);
        #2 clear = 1'b1;
        #1;
        check("async clear tx", {15'b0, TX}, 16'h0001);
        check("async clear status", bus.out, 16'h0000);
        repeat (2) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        idle_check("post-clear", 300);

        // Clean frame after clear
        do_write(16'h00A5);
        check("wA5 queued status", bus.out, 16'h8000);
        @(negedge clk);
        frame("fA5", 10'b1101001010, -1, 16'h0, -1, 16'h0);
        idle_check("postA5", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
